// File: rtl/clb_switch_box_cfg.sv
// CLB switch box: single/double/quad routing with a serial shadow/active config chain.
// Optional macro CLB_SB_CFG_PARITY_EN adds an odd-parity bit at the top of the chain.

module clb_sb_class #(
  parameter int W = 8,
  parameter int L = 1
) (
  input  logic [3:0][W-1:0]     wire_in,
  input  logic [8*(W/L)-1:0]    sel_bits,
  output logic [3:0][W-1:0]     wire_out
);
  localparam int NT = W / L;

  // Upper input bits only feed pass-through stagger; some are never consumed.
  logic unused_hi;
  assign unused_hi = ^wire_in;

  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar i = 0; i < W; i++) begin : g_trk
      if (i < NT) begin : g_sw
        logic [1:0] sel;
        assign sel = sel_bits[8*i+2*s +: 2];
        assign wire_out[s][i] = (sel == 2'b01) ? wire_in[(s+1)%4][i] :
                                (sel == 2'b10) ? wire_in[(s+2)%4][i] :
                                (sel == 2'b11) ? wire_in[(s+3)%4][i] : 1'b0;
      end else begin : g_pass
        assign wire_out[s][i] = wire_in[(s+2)%4][i-NT];
      end
    end
  end
endmodule

module clb_switch_box_cfg #(
  parameter int WS = 8,
  parameter int WD = 8,
  parameter int WQ = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [WS-1:0] north_single_in,
  input  logic [WS-1:0] east_single_in,
  input  logic [WS-1:0] south_single_in,
  input  logic [WS-1:0] west_single_in,
  output logic [WS-1:0] north_single_out,
  output logic [WS-1:0] east_single_out,
  output logic [WS-1:0] south_single_out,
  output logic [WS-1:0] west_single_out,
  input  logic [WD-1:0] north_double_in,
  input  logic [WD-1:0] east_double_in,
  input  logic [WD-1:0] south_double_in,
  input  logic [WD-1:0] west_double_in,
  output logic [WD-1:0] north_double_out,
  output logic [WD-1:0] east_double_out,
  output logic [WD-1:0] south_double_out,
  output logic [WD-1:0] west_double_out,
  input  logic [WQ-1:0] north_quad_in,
  input  logic [WQ-1:0] east_quad_in,
  input  logic [WQ-1:0] south_quad_in,
  input  logic [WQ-1:0] west_quad_in,
  output logic [WQ-1:0] north_quad_out,
  output logic [WQ-1:0] east_quad_out,
  output logic [WQ-1:0] south_quad_out,
  output logic [WQ-1:0] west_quad_out,
  input  logic          cfg_en,
  input  logic          cfg_in,
  output logic          cfg_out,
  input  logic          cfg_commit,
  output logic          cfg_done,
  output logic          cfg_err
);
  localparam int NSW = WS + WD/2 + WQ/4;
`ifdef CLB_SB_CFG_PARITY_EN
  localparam int CFG_BITS = NSW*8 + 1;
`else
  localparam int CFG_BITS = NSW*8;
`endif
  localparam int CW = $clog2(CFG_BITS+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow;
  logic [NSW*8-1:0]    active;
  logic [CW-1:0]       cnt;
  logic                parity_ok;
  logic                commit_ok;

`ifdef CLB_SB_CFG_PARITY_EN
  assign parity_ok = ^shadow;
`else
  assign parity_ok = 1'b1;
`endif
  assign commit_ok = (cnt == CNT_FULL) && parity_ok;
  assign cfg_out   = shadow[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      active   <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (cfg_en) begin
      // A commit colliding with a shift is always rejected.
      shadow   <= {cfg_in, shadow[CFG_BITS-1:1]};
      cfg_done <= 1'b0;
      if (cnt != CNT_FULL) cnt <= cnt + CW'(1);
      if (cfg_commit) cfg_err <= 1'b1;
    end else if (cfg_commit) begin
      if (commit_ok) begin
        active   <= shadow[NSW*8-1:0];
        cnt      <= '0;
        cfg_done <= 1'b1;
      end else begin
        cfg_err  <= 1'b1;
        cfg_done <= 1'b0;
      end
    end
  end

  logic [3:0][WS-1:0] s_in, s_out;
  logic [3:0][WD-1:0] d_in, d_out;
  logic [3:0][WQ-1:0] q_in, q_out;

  assign s_in = {west_single_in, south_single_in, east_single_in, north_single_in};
  assign d_in = {west_double_in, south_double_in, east_double_in, north_double_in};
  assign q_in = {west_quad_in,   south_quad_in,   east_quad_in,   north_quad_in};

  clb_sb_class #(.W(WS), .L(1)) u_single (
    .wire_in (s_in),
    .sel_bits(active[0 +: 8*WS]),
    .wire_out(s_out)
  );

  clb_sb_class #(.W(WD), .L(2)) u_double (
    .wire_in (d_in),
    .sel_bits(active[8*WS +: 8*(WD/2)]),
    .wire_out(d_out)
  );

  clb_sb_class #(.W(WQ), .L(4)) u_quad (
    .wire_in (q_in),
    .sel_bits(active[8*(WS+WD/2) +: 8*(WQ/4)]),
    .wire_out(q_out)
  );

  assign north_single_out = s_out[0];
  assign east_single_out  = s_out[1];
  assign south_single_out = s_out[2];
  assign west_single_out  = s_out[3];
  assign north_double_out = d_out[0];
  assign east_double_out  = d_out[1];
  assign south_double_out = d_out[2];
  assign west_double_out  = d_out[3];
  assign north_quad_out   = q_out[0];
  assign east_quad_out    = q_out[1];
  assign south_quad_out   = q_out[2];
  assign west_quad_out    = q_out[3];
endmodule
